// File: rtl/ascon_pack.sv
// Shared ASCON definitions: state type, round constants, rounds-select encoding and sequencer
// FSM states.
package ascon_pack;

  localparam int unsigned WordW    = 64;
  localparam int unsigned NumWords = 5;

  typedef logic [NumWords-1:0][WordW-1:0] type_state;

  localparam logic [1:0] ModeP12  = 2'b00;
  localparam logic [1:0] ModeP8   = 2'b01;
  localparam logic [1:0] ModeP6   = 2'b10;
  localparam logic [1:0] ModeRsvd = 2'b11;

  localparam logic [3:0] LastRound = 4'd11;

  localparam logic [7:0] RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } type_fsm;

  // Index of the first round applied: pN starts at 12 - N; the reserved code runs as p12.
  function automatic logic [3:0] first_round(input logic [1:0] mode);
    case (mode)
      ModeP8:  first_round = 4'd4;
      ModeP6:  first_round = 4'd6;
      default: first_round = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational ASCON round: constant addition, bitsliced 5-bit S-box, linear diffusion.
module permutation_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    ror64 = (x >> n) | (x << (64 - n));
  endfunction

  type_state   w_c;
  type_state   w_s;
  logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
  logic [7:0]  w_rc;

  assign w_rc = (round_i <= LastRound) ? RC[round_i] : 8'h00;

  always_comb begin
    w_c          = state_i;
    w_c[2][7:0]  = state_i[2][7:0] ^ w_rc;
  end

  always_comb begin
    w_x0 = w_c[0] ^ w_c[4];
    w_x1 = w_c[1];
    w_x2 = w_c[2] ^ w_c[1];
    w_x3 = w_c[3];
    w_x4 = w_c[4] ^ w_c[3];
    w_a0 = w_x0 ^ (~w_x1 & w_x2);
    w_a1 = w_x1 ^ (~w_x2 & w_x3);
    w_a2 = w_x2 ^ (~w_x3 & w_x4);
    w_a3 = w_x3 ^ (~w_x4 & w_x0);
    w_a4 = w_x4 ^ (~w_x0 & w_x1);
    w_s[0] = w_a0 ^ w_a4;
    w_s[1] = w_a1 ^ w_a0;
    w_s[2] = ~w_a2;
    w_s[3] = w_a3 ^ w_a2;
    w_s[4] = w_a4;
  end

  always_comb begin
    state_o[0] = w_s[0] ^ ror64(w_s[0], 19) ^ ror64(w_s[0], 28);
    state_o[1] = w_s[1] ^ ror64(w_s[1], 61) ^ ror64(w_s[1], 39);
    state_o[2] = w_s[2] ^ ror64(w_s[2], 1)  ^ ror64(w_s[2], 6);
    state_o[3] = w_s[3] ^ ror64(w_s[3], 10) ^ ror64(w_s[3], 17);
    state_o[4] = w_s[4] ^ ror64(w_s[4], 7)  ^ ror64(w_s[4], 41);
  end

endmodule

// File: rtl/ascon_permutation_seq.sv
// Iterative ASCON p12/p8/p6 sequencer: one round per clock with a start/done handshake.
module ascon_permutation_seq
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  type_fsm    r_fsm,   w_fsm_d;
  logic [3:0] r_cnt,   w_cnt_d;
  logic [3:0] r_round, w_round_d;
  type_state  r_state, w_state_d;

  type_state  w_rnd_in;
  type_state  w_rnd_out;
  logic [3:0] w_rnd_idx;

  // The single round instance is fed from the input port on a start, else from the register.
  always_comb begin
    if (r_fsm == StIdle) begin
      w_rnd_in  = state_i;
      w_rnd_idx = first_round(mode_i);
    end else begin
      w_rnd_in  = r_state;
      w_rnd_idx = r_cnt;
    end
  end

  permutation_round u_round (
    .state_i (w_rnd_in),
    .round_i (w_rnd_idx),
    .state_o (w_rnd_out)
  );

  always_comb begin
    w_fsm_d   = r_fsm;
    w_cnt_d   = r_cnt;
    w_round_d = r_round;
    w_state_d = r_state;
    case (r_fsm)
      StIdle: begin
        if (start_i) begin
          w_state_d = w_rnd_out;
          w_round_d = w_rnd_idx;
          w_cnt_d   = w_rnd_idx + 4'd1;
          w_fsm_d   = (w_rnd_idx == LastRound) ? StDone : StRun;
        end
      end
      StRun: begin
        w_state_d = w_rnd_out;
        w_round_d = r_cnt;
        // Counter holds at 11 so it never leaves the 0..11 range.
        if (r_cnt == LastRound) w_fsm_d = StDone;
        else                    w_cnt_d = r_cnt + 4'd1;
      end
      StDone:  w_fsm_d = StIdle;
      default: w_fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= StIdle;
      r_cnt   <= 4'd0;
      r_round <= 4'd0;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_d;
      r_cnt   <= w_cnt_d;
      r_round <= w_round_d;
      r_state <= w_state_d;
    end
  end

  assign state_o = r_state;
  assign round_o = r_round;
  assign busy_o  = (r_fsm == StRun);
  assign done_o  = (r_fsm == StDone);

endmodule

// File: tb/tb_ascon_permutation_seq.sv
// Scoreboard bench for ascon_permutation_seq against a table-driven ASCON reference model.
module tb_ascon_permutation_seq;
  import ascon_pack::*;

  logic       clock_i  = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i  = 1'b0;
  logic [1:0] mode_i   = 2'b00;
  type_state  state_i  = '0;
  type_state  state_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  int n_cmp = 0;
  int n_bad = 0;
  longint unsigned edge_cnt = 0;

  typedef struct {
    type_state       st;
    int unsigned     n;
    int unsigned     r0;
    longint unsigned t0;
  } exp_t;

  exp_t      q[$];
  exp_t      cur;
  bit        cur_v   = 1'b0;
  type_state last_st = '0;
  logic [3:0] last_rd = 4'd0;
  type_state vec;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int unsigned ROT [5][2] = '{'{19, 28}, '{61, 39}, '{1, 6}, '{10, 17}, '{7, 41}};

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) edge_cnt <= edge_cnt + 1;

  ascon_permutation_seq dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .state_i  (state_i),
    .state_o  (state_o),
    .round_o  (round_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state ref_round(input type_state s, input int unsigned r);
    type_state  t;
    logic [4:0] col;
    logic [4:0] o;
    s[2] = s[2] ^ 64'(((15 - r) << 4) | r);
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o   = SBOX[col];
      for (int w = 0; w < 5; w++) t[w][b] = o[4-w];
    end
    for (int w = 0; w < 5; w++) s[w] = t[w] ^ rotr(t[w], ROT[w][0]) ^ rotr(t[w], ROT[w][1]);
    return s;
  endfunction

  function automatic int unsigned rounds_of(input logic [1:0] m);
    case (m)
      2'b01:   return 8;
      2'b10:   return 6;
      default: return 12;
    endcase
  endfunction

  function automatic type_state ref_perm(input type_state s, input int unsigned n);
    for (int unsigned r = 12 - n; r < 12; r++) s = ref_round(s, r);
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++)
      for (int h = 0; h < 2; h++) s[w][h*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and checks against the queue.
  initial begin
    longint unsigned k;
    forever begin
      @(posedge clock_i);
      #1;
      if (!resetb_i) begin
        cur_v   = 1'b0;
        q.delete();
        last_st = '0;
        last_rd = 4'd0;
        chk("rst_state_o", state_o, '0);
        chk("rst_round_o", round_o, 0);
        chk("rst_busy_o", busy_o, 0);
        chk("rst_done_o", done_o, 0);
      end else begin
        if (!cur_v && q.size() > 0 && q[0].t0 <= edge_cnt) begin
          if (q[0].t0 == edge_cnt) cur_v = 1'b1;
          else chk("start_accept_edge", edge_cnt, q[0].t0);
          cur = q.pop_front();
        end
        if (cur_v) begin
          k = edge_cnt - cur.t0;
          chk("round_o", round_o, cur.r0 + k);
          chk("busy_o", busy_o, k < cur.n - 1);
          chk("done_o", done_o, k == cur.n - 1);
          if (k == cur.n - 1) begin
            chk("state_o_result", state_o, cur.st);
            last_st = cur.st;
            last_rd = 4'd11;
            cur_v   = 1'b0;
          end
        end else begin
          chk("idle_busy_o", busy_o, 0);
          chk("idle_done_o", done_o, 0);
          chk("idle_state_o_hold", state_o, last_st);
          chk("idle_round_o_hold", round_o, last_rd);
        end
      end
    end
  end

  task automatic run_perm(input logic [1:0] m, input type_state s, input bit noise);
    int unsigned n;
    n = rounds_of(m);
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = m;
    state_i = s;
    q.push_back('{st: ref_perm(s, n), n: n, r0: 12 - n, t0: edge_cnt + 1});
    // Starts during RUN and DONE must be ignored.
    for (int j = 1; j <= int'(n); j++) begin
      @(negedge clock_i);
      start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        mode_i  = 2'($urandom_range(0, 3));
        state_i = rand_state();
      end
    end
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (2) @(negedge clock_i);
  endtask

  initial begin
    longint unsigned t0;
    vec[0] = 64'h80400c0600000000;
    vec[1] = 64'h8a55114d1cb6a9a2;
    vec[2] = 64'hbe263d4d7aecaaff;
    vec[3] = 64'h4ed0ec0b98c529b7;
    vec[4] = 64'hc8cddf37bcd0284a;

    resetb_i = 1'b0;
    repeat (4) begin
      @(negedge clock_i);
      start_i = 1'($urandom_range(0, 1));
      mode_i  = 2'($urandom_range(0, 3));
      state_i = rand_state();
    end
    @(negedge clock_i);
    start_i  = 1'b0;
    resetb_i = 1'b1;
    repeat (2) @(negedge clock_i);

    run_perm(2'b00, vec, 1'b0);
    run_perm(2'b10, vec, 1'b0);
    run_perm(2'b01, vec, 1'b0);
    run_perm(2'b11, vec, 1'b1);
    repeat (10) run_perm(2'($urandom_range(0, 3)), rand_state(), 1'b1);

    // start_i held for 20 cycles: second p12 accepted the cycle after done_o.
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 2'b00;
    state_i = vec;
    t0 = edge_cnt + 1;
    q.push_back('{st: ref_perm(vec, 12), n: 12, r0: 0, t0: t0});
    q.push_back('{st: ref_perm(vec, 12), n: 12, r0: 0, t0: t0 + 13});
    repeat (20) @(negedge clock_i);
    start_i = 1'b0;
    repeat (8) @(negedge clock_i);

    // Asynchronous reset in the middle of a p12.
    @(negedge clock_i);
    start_i = 1'b1;
    mode_i  = 2'b00;
    state_i = vec;
    q.push_back('{st: ref_perm(vec, 12), n: 12, r0: 0, t0: edge_cnt + 1});
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (4) @(negedge clock_i);
    #2 resetb_i = 1'b0;
    #1;
    chk("async_rst_state_o", state_o, '0);
    chk("async_rst_round_o", round_o, 0);
    chk("async_rst_busy_o", busy_o, 0);
    chk("async_rst_done_o", done_o, 0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    repeat (14) @(negedge clock_i);
    run_perm(2'b00, vec, 1'b0);

    repeat (2) @(negedge clock_i);
    chk("queue_drained", q.size(), 0);
    chk("no_open_transaction", cur_v, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
